// File: rtl/pipe_mem_pkg.sv
// Shared encodings for the MEM stage: access sizes, access FSM states, wait counter width.
// Build option MISALIGN_TRAP_EN uses is_misaligned() to reject unaligned half/word accesses.
package pipe_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int WAIT_CNT_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // Size 2'b11 behaves as a word everywhere in this stage.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a_lo);
        logic r;
        case (size)
            SZ_BYTE: r = 1'b0;
            SZ_HALF: r = a_lo[0];
            default: r = (a_lo != 2'b00);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pipe_mem_stage_lane_align.sv
// Combinational lane logic: byte enables and replicated store data on the way out,
// lane extraction and sign/zero extension of load data on the way back.
module mem_lane_align
    import pipe_mem_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_load_uns,
    input  logic [31:0] i_st_data,
    input  logic [31:0] i_ld_word,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ld_data
);

    logic [31:0] w_ld_shift;

    assign w_ld_shift = i_ld_word >> {i_addr_lo, 3'b000};

    always_comb begin
        o_be      = 4'hF;
        o_wdata   = i_st_data;
        o_ld_data = i_ld_word;
        case (i_size)
            SZ_BYTE: begin
                o_be      = 4'b0001 << i_addr_lo;
                o_wdata   = {4{i_st_data[7:0]}};
                o_ld_data = {{24{w_ld_shift[7] & ~i_load_uns}}, w_ld_shift[7:0]};
            end
            SZ_HALF: begin
                // Only a[1] picks the half; a[0] is ignored unless trapped upstream.
                o_be      = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata   = {2{i_st_data[15:0]}};
                o_ld_data = i_addr_lo[1]
                          ? {{16{i_ld_word[31] & ~i_load_uns}}, i_ld_word[31:16]}
                          : {{16{i_ld_word[15] & ~i_load_uns}}, i_ld_word[15:0]};
            end
            default: begin
                o_be      = 4'hF;
                o_wdata   = i_st_data;
                o_ld_data = i_ld_word;
            end
        endcase
    end

endmodule

// File: rtl/pipe_mem_stage.sv
// MEM pipeline stage: EX/MEM register, req/ack data-memory access FSM with timeout, MEM/WB register.
// Define MISALIGN_TRAP_EN to trap unaligned half/word accesses and add the mem_misalign output.
module pipe_mem_stage
    import pipe_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        flush,
    input  logic [31:0] exe_alu_out,
    input  logic [31:0] exe_pc4,
    input  logic [31:0] exe_rt_data_out,
    input  logic [4:0]  exe_rf_waddr,
    input  logic        exe_dmem_ena,
    input  logic        exe_dmem_wena,
    input  logic [1:0]  exe_mem_size,
    input  logic        exe_load_uns,
    input  logic        exe_rf_wena,
    input  logic [2:0]  exe_rf_mux_sel,
    output logic        stall_out,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        mem_valid,
    output logic [31:0] mem_alu_out,
    output logic [31:0] mem_pc4,
    output logic [31:0] mem_rdata,
    output logic [4:0]  mem_rf_waddr,
    output logic        mem_rf_wena,
    output logic [2:0]  mem_rf_mux_sel,
    output logic        mem_bus_err
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        mem_misalign
`endif
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(TIMEOUT_CYCLES);

    logic                  r_ex_valid;
    logic [31:0]           r_ex_alu_out;
    logic [31:0]           r_ex_pc4;
    logic [31:0]           r_ex_rt_data;
    logic [4:0]            r_ex_rf_waddr;
    logic                  r_ex_dmem_ena;
    logic                  r_ex_dmem_wena;
    logic [1:0]            r_ex_mem_size;
    logic                  r_ex_load_uns;
    logic                  r_ex_rf_wena;
    logic [2:0]            r_ex_rf_mux_sel;

    mem_state_t            r_state;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;

    logic                  w_mem_op;
    logic                  w_misalign;
    logic                  w_abort;
    logic                  w_ack;
    logic [31:0]           w_ld_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ex_valid      <= 1'b0;
            r_ex_alu_out    <= '0;
            r_ex_pc4        <= '0;
            r_ex_rt_data    <= '0;
            r_ex_rf_waddr   <= '0;
            r_ex_dmem_ena   <= 1'b0;
            r_ex_dmem_wena  <= 1'b0;
            r_ex_mem_size   <= '0;
            r_ex_load_uns   <= 1'b0;
            r_ex_rf_wena    <= 1'b0;
            r_ex_rf_mux_sel <= '0;
        end else if (!stall_out) begin
            r_ex_valid      <= in_valid & ~flush;
            r_ex_alu_out    <= exe_alu_out;
            r_ex_pc4        <= exe_pc4;
            r_ex_rt_data    <= exe_rt_data_out;
            r_ex_rf_waddr   <= exe_rf_waddr;
            r_ex_dmem_ena   <= exe_dmem_ena;
            r_ex_dmem_wena  <= exe_dmem_wena;
            r_ex_mem_size   <= exe_mem_size;
            r_ex_load_uns   <= exe_load_uns;
            r_ex_rf_wena    <= exe_rf_wena;
            r_ex_rf_mux_sel <= exe_rf_mux_sel;
        end
    end

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = r_ex_valid & r_ex_dmem_ena & is_misaligned(r_ex_mem_size, r_ex_alu_out[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    // The abort cycle itself does not stall, so the bundle retires that same cycle.
    assign w_mem_op  = r_ex_valid & r_ex_dmem_ena & ~w_misalign;
    assign w_ack     = w_mem_op & dm_ack;
    assign w_abort   = (r_state == WAIT) & w_mem_op & ~dm_ack & (r_wait_cnt == TIMEOUT_CNT);
    assign stall_out = w_mem_op & ~dm_ack & ~w_abort;

    assign dm_req  = w_mem_op;
    assign dm_we   = w_mem_op & r_ex_dmem_wena;
    assign dm_addr = {r_ex_alu_out[31:2], 2'b00};

    mem_lane_align u_lane (
        .i_addr_lo  (r_ex_alu_out[1:0]),
        .i_size     (r_ex_mem_size),
        .i_load_uns (r_ex_load_uns),
        .i_st_data  (r_ex_rt_data),
        .i_ld_word  (dm_rdata),
        .o_be       (dm_be),
        .o_wdata    (dm_wdata),
        .o_ld_data  (w_ld_data)
    );

    // Counter holds the number of wait cycles already spent on the current access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_mem_op && !dm_ack) begin
                        r_state    <= WAIT;
                        r_wait_cnt <= WAIT_CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (!w_mem_op || dm_ack || w_abort) begin
                        r_state    <= IDLE;
                        r_wait_cnt <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_CNT_W'(1);
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_valid      <= 1'b0;
            mem_alu_out    <= '0;
            mem_pc4        <= '0;
            mem_rdata      <= '0;
            mem_rf_waddr   <= '0;
            mem_rf_wena    <= 1'b0;
            mem_rf_mux_sel <= '0;
            mem_bus_err    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            mem_misalign   <= 1'b0;
`endif
        end else if (!stall_out) begin
            mem_valid      <= r_ex_valid;
            mem_alu_out    <= r_ex_alu_out;
            mem_pc4        <= r_ex_pc4;
            mem_rdata      <= (w_ack && !r_ex_dmem_wena) ? w_ld_data : 32'h0;
            mem_rf_waddr   <= r_ex_rf_waddr;
            mem_rf_wena    <= r_ex_valid & r_ex_rf_wena & ~w_abort & ~w_misalign;
            mem_rf_mux_sel <= r_ex_rf_mux_sel;
            mem_bus_err    <= w_abort;
`ifdef MISALIGN_TRAP_EN
            mem_misalign   <= w_misalign;
`endif
        end else begin
            mem_valid      <= 1'b0;
            mem_rf_wena    <= 1'b0;
            mem_bus_err    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            mem_misalign   <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Self-checking bench for pipe_mem_stage: directed spec cases plus randomized ops against a
// per-instruction reference model; memory responder acks after a chosen number of wait cycles.
module tb_pipe_mem_stage;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        flush;
    logic [31:0] exe_alu_out;
    logic [31:0] exe_pc4;
    logic [31:0] exe_rt_data_out;
    logic [4:0]  exe_rf_waddr;
    logic        exe_dmem_ena;
    logic        exe_dmem_wena;
    logic [1:0]  exe_mem_size;
    logic        exe_load_uns;
    logic        exe_rf_wena;
    logic [2:0]  exe_rf_mux_sel;
    logic        stall_out;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        mem_valid;
    logic [31:0] mem_alu_out;
    logic [31:0] mem_pc4;
    logic [31:0] mem_rdata;
    logic [4:0]  mem_rf_waddr;
    logic        mem_rf_wena;
    logic [2:0]  mem_rf_mux_sel;
    logic        mem_bus_err;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .flush           (flush),
        .exe_alu_out     (exe_alu_out),
        .exe_pc4         (exe_pc4),
        .exe_rt_data_out (exe_rt_data_out),
        .exe_rf_waddr    (exe_rf_waddr),
        .exe_dmem_ena    (exe_dmem_ena),
        .exe_dmem_wena   (exe_dmem_wena),
        .exe_mem_size    (exe_mem_size),
        .exe_load_uns    (exe_load_uns),
        .exe_rf_wena     (exe_rf_wena),
        .exe_rf_mux_sel  (exe_rf_mux_sel),
        .stall_out       (stall_out),
        .dm_req          (dm_req),
        .dm_we           (dm_we),
        .dm_addr         (dm_addr),
        .dm_be           (dm_be),
        .dm_wdata        (dm_wdata),
        .dm_ack          (dm_ack),
        .dm_rdata        (dm_rdata),
        .mem_valid       (mem_valid),
        .mem_alu_out     (mem_alu_out),
        .mem_pc4         (mem_pc4),
        .mem_rdata       (mem_rdata),
        .mem_rf_waddr    (mem_rf_waddr),
        .mem_rf_wena     (mem_rf_wena),
        .mem_rf_mux_sel  (mem_rf_mux_sel),
        .mem_bus_err     (mem_bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference lane model: plain arithmetic on offsets and replication multipliers.
    task automatic ref_lane(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] rt,
                            input logic [31:0] rd, input logic uns,
                            output logic [3:0] be, output logic [31:0] wd, output logic [31:0] ld);
        int unsigned off;
        logic [31:0] x;
        off = a % 4;
        if (sz == 2'd0) begin
            be = 4'(1 << off);
            wd = (rt & 32'hFF) * 32'h01010101;
            x  = (rd >> (8 * off)) & 32'hFF;
            ld = (!uns && x >= 32'h80) ? (x | 32'hFFFFFF00) : x;
        end else if (sz == 2'd1) begin
            off = (off / 2) * 2;
            be = 4'(3 << off);
            wd = (rt & 32'hFFFF) * 32'h00010001;
            x  = (rd >> (8 * off)) & 32'hFFFF;
            ld = (!uns && x >= 32'h8000) ? (x | 32'hFFFF0000) : x;
        end else begin
            be = 4'hF;
            wd = rt;
            ld = rd;
        end
    endtask

    // One instruction through the stage; w = cycle index of the ack (w > TO means it never comes).
    task automatic run_op(input logic v, input logic fl, input logic [31:0] a, input logic [31:0] pc4,
                          input logic [31:0] rt, input logic [4:0] wa, input logic ena,
                          input logic wena, input logic [1:0] sz, input logic uns,
                          input logic rfw, input logic [2:0] mux, input int w,
                          input logic [31:0] ack_rdata);
        logic vld, is_mem, abort;
        int k;
        logic [3:0]  e_be;
        logic [31:0] e_wd, e_ld, rd, rd_at_ack, e_rdata;
        vld    = v & ~fl;
        is_mem = vld & ena;
        abort  = is_mem && (w > TO);
        k      = !is_mem ? 0 : ((w > TO) ? TO : w);
        rd_at_ack = 32'h0;
        ref_lane(sz, a, rt, 32'h0, uns, e_be, e_wd, e_ld);

        @(negedge clk);
        in_valid = v; flush = fl; exe_alu_out = a; exe_pc4 = pc4; exe_rt_data_out = rt;
        exe_rf_waddr = wa; exe_dmem_ena = ena; exe_dmem_wena = wena; exe_mem_size = sz;
        exe_load_uns = uns; exe_rf_wena = rfw; exe_rf_mux_sel = mux; dm_ack = 1'b0;
        @(negedge clk);
        // Upstream garbage with in_valid=0: must not disturb a stalled EX/MEM entry.
        in_valid = 1'b0; flush = 1'($urandom_range(0, 1)); exe_alu_out = $urandom;
        exe_rt_data_out = $urandom; exe_mem_size = 2'($urandom_range(0, 3));
        exe_dmem_wena = 1'($urandom_range(0, 1)); exe_dmem_ena = 1'b1;

        for (int c = 0; c <= k; c++) begin
            rd = $urandom;
            if (is_mem) begin
                dm_ack = (c == w);
                if (c == w) begin
                    rd = ack_rdata;
                    rd_at_ack = rd;
                end
            end else begin
                dm_ack = 1'($urandom_range(0, 1));
            end
            dm_rdata = rd;
            #1;
            chk("stall_out", {31'h0, stall_out}, {31'h0, is_mem && (c < k)});
            chk("dm_req", {31'h0, dm_req}, {31'h0, is_mem});
            chk("mem_valid_bubble", {31'h0, mem_valid}, 32'h0);
            if (is_mem) begin
                chk("dm_addr", dm_addr, a & 32'hFFFF_FFFC);
                chk("dm_be", {28'h0, dm_be}, {28'h0, e_be});
                chk("dm_we", {31'h0, dm_we}, {31'h0, wena});
                if (wena) chk("dm_wdata", dm_wdata, e_wd);
            end
            @(negedge clk);
        end
        dm_ack = 1'b0;
        #1;
        ref_lane(sz, a, rt, rd_at_ack, uns, e_be, e_wd, e_ld);
        e_rdata = (is_mem && !wena && !abort) ? e_ld : 32'h0;
        chk("mem_valid", {31'h0, mem_valid}, {31'h0, vld});
        if (vld) begin
            chk("mem_alu_out", mem_alu_out, a);
            chk("mem_pc4", mem_pc4, pc4);
            chk("mem_rf_waddr", {27'h0, mem_rf_waddr}, {27'h0, wa});
            chk("mem_rf_mux_sel", {29'h0, mem_rf_mux_sel}, {29'h0, mux});
            chk("mem_rf_wena", {31'h0, mem_rf_wena}, {31'h0, rfw & ~abort});
            chk("mem_bus_err", {31'h0, mem_bus_err}, {31'h0, abort});
            chk("mem_rdata", mem_rdata, e_rdata);
        end
        $display("[TB] op v=%b fl=%b mem=%b we=%b sz=%0d a=%h waits=%0d abort=%b -> valid=%b rdata=%h err=%b",
                 v, fl, ena, wena, sz, a, k, abort, mem_valid, mem_rdata, mem_bus_err);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; flush = 1'b0; exe_alu_out = '0; exe_pc4 = '0;
        exe_rt_data_out = '0; exe_rf_waddr = '0; exe_dmem_ena = 1'b0; exe_dmem_wena = 1'b0;
        exe_mem_size = '0; exe_load_uns = 1'b0; exe_rf_wena = 1'b0; exe_rf_mux_sel = '0;
        dm_ack = 1'b0; dm_rdata = '0;
        #1;
        chk("rst_stall_out", {31'h0, stall_out}, 32'h0);
        chk("rst_dm_req", {31'h0, dm_req}, 32'h0);
        chk("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
        chk("rst_mem_alu_out", mem_alu_out, 32'h0);
        chk("rst_mem_rdata", mem_rdata, 32'h0);
        chk("rst_mem_bus_err", {31'h0, mem_bus_err}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // ALU op, word load with 3 waits, byte loads signed/unsigned, half store, timeout, flush
        run_op(1, 0, 32'h1234, 32'h1004, 32'h0, 5'd5, 0, 0, 2'd2, 0, 1, 3'd1, 0, 32'h0);
        run_op(1, 0, 32'h100, 32'h2004, 32'h0, 5'd7, 1, 0, 2'd2, 0, 1, 3'd2, 3, 32'hDEADBEEF);
        run_op(1, 0, 32'h103, 32'h3004, 32'h0, 5'd8, 1, 0, 2'd0, 0, 1, 3'd2, 0, 32'h80123456);
        run_op(1, 0, 32'h103, 32'h3008, 32'h0, 5'd9, 1, 0, 2'd0, 1, 1, 3'd2, 0, 32'h80123456);
        run_op(1, 0, 32'h102, 32'h4004, 32'h0000ABCD, 5'd0, 1, 1, 2'd1, 0, 0, 3'd0, 1, 32'h0);
        run_op(1, 0, 32'h300, 32'h5004, 32'h0, 5'd3, 1, 0, 2'd2, 0, 1, 3'd2, 100, 32'h0);
        run_op(1, 1, 32'h400, 32'h6004, 32'h0, 5'd4, 1, 0, 2'd2, 0, 1, 3'd2, 0, 32'h0);
        run_op(1, 0, 32'h302, 32'h7004, 32'h0, 5'd6, 1, 0, 2'd1, 0, 1, 3'd2, 4, 32'h1234F00D);

        // Async reset in the middle of a wait
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b0; exe_alu_out = 32'h200; exe_dmem_ena = 1'b1;
        exe_dmem_wena = 1'b0; exe_mem_size = 2'd2; exe_rf_wena = 1'b1; dm_ack = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("pre_rst_dm_req", {31'h0, dm_req}, 32'h1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_dm_req", {31'h0, dm_req}, 32'h0);
        chk("mid_rst_stall_out", {31'h0, stall_out}, 32'h0);
        chk("mid_rst_mem_valid", {31'h0, mem_valid}, 32'h0);
        $display("[TB] reset during wait: dm_req=%b stall_out=%b mem_valid=%b", dm_req, stall_out, mem_valid);
        @(negedge clk);
        rst = 1'b1;
        run_op(1, 0, 32'h204, 32'h8004, 32'h0, 5'd10, 1, 0, 2'd2, 0, 1, 3'd2, 2, 32'hCAFEF00D);

        for (int i = 0; i < 40; i++) begin
            run_op(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 5) == 0), $urandom, $urandom,
                   $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0),
                   1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), int'($urandom_range(0, 6)),
                   $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
